chunk_fill_controller: RTL and testbench
========================================

CHUNK_FILL_CONTROLLER -- requirements
Module: chunk_fill_controller

Interface
REQ-001 Parameter CHUNK_PART, default 128, SHALL set the chunk width in bits.
REQ-002 Parameter ADDRESS_SIZE, default 28, SHALL set the byte address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 miss_valid  input  1  SHALL signal a pool miss request.
REQ-006 miss_address  input  ADDRESS_SIZE  SHALL carry the missing byte address.
REQ-007 miss_ready  output  1  SHALL indicate the controller accepts a miss.
REQ-008 miss_done  output  1  SHALL pulse once when the miss is serviced.
REQ-009 save_need_flag  input  1  SHALL indicate the pool victim chunk is dirty.
REQ-010 save_address  input  ADDRESS_SIZE  SHALL carry the victim chunk address.
REQ-011 save_data  input  CHUNK_PART  SHALL carry the victim chunk data.
REQ-012 new_address  output  ADDRESS_SIZE  SHALL carry the fill chunk address.
REQ-013 new_data  output  CHUNK_PART  SHALL carry the fill chunk data.
REQ-014 new_data_save  output  1  SHALL be a one-cycle fill strobe to the pool.
REQ-015 mem_cmd_valid / mem_cmd_ready  output / input  1 / 1  SHALL form the memory command handshake.
REQ-016 mem_cmd_write  output  1  SHALL select write (1) or read (0).
REQ-017 mem_cmd_address  output  ADDRESS_SIZE  SHALL carry the chunk-aligned memory address.
REQ-018 mem_wr_data  output  CHUNK_PART  SHALL carry write-back data.
REQ-019 mem_rd_valid / mem_rd_data  input  1 / CHUNK_PART  SHALL return read data, one beat per read.

Function
REQ-020 The controller SHALL implement states IDLE, WB_REQ, RD_REQ, RD_WAIT, FILL, DONE.
REQ-021 miss_ready SHALL equal 1 only in IDLE; acceptance = miss_valid && miss_ready.
REQ-022 On acceptance the controller SHALL latch {miss_address[ADDRESS_SIZE-1:4], 4'b0}, save_need_flag, save_address and save_data; later changes on those inputs SHALL be ignored.
REQ-023 From IDLE on acceptance the controller SHALL enter WB_REQ if the latched save_need_flag is 1, else RD_REQ.
REQ-024 In WB_REQ: mem_cmd_valid=1, mem_cmd_write=1, mem_cmd_address = latched save_address with low 4 bits zeroed, mem_wr_data = latched save_data; on mem_cmd_ready go to RD_REQ.
REQ-025 In RD_REQ: mem_cmd_valid=1, mem_cmd_write=0, mem_cmd_address = latched aligned miss address; on mem_cmd_ready go to RD_WAIT.
REQ-026 mem_cmd_valid and command fields SHALL stay stable until mem_cmd_ready; mem_cmd_ready asserted in the first cycle of valid SHALL complete the handshake that cycle.
REQ-027 In RD_WAIT, on mem_rd_valid the controller SHALL register mem_rd_data into new_data and enter FILL; mem_rd_valid in any other state SHALL be ignored.
REQ-028 In FILL, new_data_save SHALL be 1 for exactly one cycle with new_address = latched aligned miss address; then enter DONE.
REQ-029 In DONE, miss_done SHALL be 1 for exactly one cycle; then return to IDLE.
REQ-030 Minimum latency acceptance->miss_done SHALL be 4 cycles without write-back and 5 with, with zero-wait memory.
REQ-031 new_data and new_address SHALL hold their last values outside FILL; mem_cmd_valid SHALL be 0 outside WB_REQ/RD_REQ.

Reset
REQ-032 On rst_n=0, at any point including mid-transaction, the state SHALL become IDLE and miss_done, new_data_save, mem_cmd_valid, mem_cmd_write, mem_cmd_address, mem_wr_data, new_address and new_data SHALL be 0, with no pending transaction resumed.
REQ-033 miss_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-034 The state enum and CHUNK_ALIGN_BITS=4 SHALL live in shared package chunk_mem_pkg.
REQ-035 The block SHALL be one module with no sub-modules.

Verification
REQ-036 Clean miss 0x0A5000F, mem_cmd_ready=1, read returns {DEADBEEF,CAFEBABE,12345678,87654321} -> one read cmd to 0x0A50000, new_address=0x0A50000, new_data matches, miss_done 4 cycles after acceptance.
REQ-037 Dirty miss, save_address=0x0A50060, save_data=4x12345678, miss 0x0A50084 -> write cmd to 0x0A50060 with that data, then read cmd to 0x0A50080.
REQ-038 mem_cmd_ready held 0 for 3 cycles -> command fields stable throughout, single handshake, no duplicate command.
REQ-039 miss_valid held during busy and spurious mem_rd_valid in IDLE -> miss_ready=0 while busy, no extra fill or command.
REQ-040 rst_n pulsed low in RD_WAIT -> all outputs 0, miss_ready=1 next cycle, late mem_rd_valid ignored.

Source files
------------

// File: rtl/chunk_mem_pkg.sv
// Shared types for the chunk pool memory path.
// Holds the fill controller state encoding and chunk alignment.
package chunk_mem_pkg;

   localparam int CHUNK_ALIGN_BITS = 4;

   typedef enum logic [2:0] {
      IDLE,
      WB_REQ,
      RD_REQ,
      RD_WAIT,
      FILL,
      DONE
   } fill_state_e;

endpackage

// File: rtl/chunk_fill_controller.sv
// Services pool misses: optional dirty write-back, chunk read,
// then a one-cycle fill strobe and a one-cycle done pulse.
module chunk_fill_controller
   import chunk_mem_pkg::*;
#(
   parameter int CHUNK_PART   = 128,
   parameter int ADDRESS_SIZE = 28
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    miss_valid,
   input  logic [ADDRESS_SIZE-1:0] miss_address,
   output logic                    miss_ready,
   output logic                    miss_done,
   input  logic                    save_need_flag,
   input  logic [ADDRESS_SIZE-1:0] save_address,
   input  logic [CHUNK_PART-1:0]   save_data,
   output logic [ADDRESS_SIZE-1:0] new_address,
   output logic [CHUNK_PART-1:0]   new_data,
   output logic                    new_data_save,
   output logic                    mem_cmd_valid,
   input  logic                    mem_cmd_ready,
   output logic                    mem_cmd_write,
   output logic [ADDRESS_SIZE-1:0] mem_cmd_address,
   output logic [CHUNK_PART-1:0]   mem_wr_data,
   input  logic                    mem_rd_valid,
   input  logic [CHUNK_PART-1:0]   mem_rd_data
);

   localparam int AW = ADDRESS_SIZE;
   localparam int CW = CHUNK_PART;

   // Clears the low address bits so every memory access is chunk aligned.
   localparam logic [AW-1:0] ALIGN_MASK =
      {{(AW-CHUNK_ALIGN_BITS){1'b1}}, {CHUNK_ALIGN_BITS{1'b0}}};

   fill_state_e   state_q, state_d;
   logic [AW-1:0] miss_addr_q, miss_addr_d;
   logic          save_flag_q, save_flag_d;
   logic [AW-1:0] save_addr_q, save_addr_d;
   logic [CW-1:0] save_data_q, save_data_d;
   logic [AW-1:0] new_addr_q, new_addr_d;
   logic [CW-1:0] new_data_q, new_data_d;

   // Next-state and capture logic; request fields are frozen at acceptance.
   always_comb begin
      state_d     = state_q;
      miss_addr_d = miss_addr_q;
      save_flag_d = save_flag_q;
      save_addr_d = save_addr_q;
      save_data_d = save_data_q;
      new_addr_d  = new_addr_q;
      new_data_d  = new_data_q;
      unique case (state_q)
         IDLE: begin
            if (miss_valid) begin
               miss_addr_d = miss_address & ALIGN_MASK;
               save_flag_d = save_need_flag;
               save_addr_d = save_address & ALIGN_MASK;
               save_data_d = save_data;
               state_d     = save_need_flag ? WB_REQ : RD_REQ;
            end
         end
         WB_REQ: begin
            if (mem_cmd_ready) state_d = RD_REQ;
         end
         RD_REQ: begin
            if (mem_cmd_ready) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_rd_valid) begin
               new_data_d = mem_rd_data;
               new_addr_d = miss_addr_q;
               state_d    = FILL;
            end
         end
         FILL:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Decoded outputs; command fields are zero outside the request states.
   always_comb begin
      miss_ready      = 1'b0;
      miss_done       = 1'b0;
      new_data_save   = 1'b0;
      mem_cmd_valid   = 1'b0;
      mem_cmd_write   = 1'b0;
      mem_cmd_address = '0;
      mem_wr_data     = '0;
      unique case (state_q)
         IDLE: miss_ready = 1'b1;
         WB_REQ: begin
            mem_cmd_valid   = 1'b1;
            mem_cmd_write   = 1'b1;
            mem_cmd_address = save_addr_q;
            mem_wr_data     = save_data_q;
         end
         RD_REQ: begin
            mem_cmd_valid   = 1'b1;
            mem_cmd_address = miss_addr_q;
         end
         FILL:    new_data_save = 1'b1;
         DONE:    miss_done     = 1'b1;
         default: ;
      endcase
   end

   assign new_address = new_addr_q;
   assign new_data    = new_data_q;

   // State and datapath registers; reset abandons any transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         miss_addr_q <= '0;
         save_flag_q <= 1'b0;
         save_addr_q <= '0;
         save_data_q <= '0;
         new_addr_q  <= '0;
         new_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         miss_addr_q <= miss_addr_d;
         save_flag_q <= save_flag_d;
         save_addr_q <= save_addr_d;
         save_data_q <= save_data_d;
         new_addr_q  <= new_addr_d;
         new_data_q  <= new_data_d;
      end
   end

endmodule

// File: tb/tb_chunk_fill_controller.sv
// Scoreboard bench for chunk_fill_controller.
// Expected commands and fills are queued at stimulus time.
module tb_chunk_fill_controller;

   localparam int CW = 128;
   localparam int AW = 28;
   localparam logic [AW-1:0] MASK = ~(AW'(4'hF));

   typedef struct {
      logic          w;
      logic [AW-1:0] a;
      logic [CW-1:0] d;
   } cmd_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [CW-1:0] d;
   } fill_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          miss_valid;
   logic [AW-1:0] miss_address;
   logic          miss_ready;
   logic          miss_done;
   logic          save_need_flag;
   logic [AW-1:0] save_address;
   logic [CW-1:0] save_data;
   logic [AW-1:0] new_address;
   logic [CW-1:0] new_data;
   logic          new_data_save;
   logic          mem_cmd_valid;
   logic          mem_cmd_ready;
   logic          mem_cmd_write;
   logic [AW-1:0] mem_cmd_address;
   logic [CW-1:0] mem_wr_data;
   logic          mem_rd_valid;
   logic [CW-1:0] mem_rd_data;

   int passed = 0;
   int total  = 0;

   cmd_t  cmd_q[$];
   fill_t fill_q[$];

   logic          pv, pr, pw;
   logic [AW-1:0] pa;
   logic [CW-1:0] pd;

   chunk_fill_controller #(.CHUNK_PART(CW), .ADDRESS_SIZE(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .miss_valid(miss_valid), .miss_address(miss_address),
      .miss_ready(miss_ready), .miss_done(miss_done),
      .save_need_flag(save_need_flag), .save_address(save_address),
      .save_data(save_data),
      .new_address(new_address), .new_data(new_data),
      .new_data_save(new_data_save),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_write(mem_cmd_write), .mem_cmd_address(mem_cmd_address),
      .mem_wr_data(mem_wr_data),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   function automatic logic [CW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Scoreboard monitor: command handshakes, fills, and stall stability.
   always @(negedge clk) begin
      if (!rst_n) begin
         pv = 1'b0;
         pr = 1'b0;
      end else begin
         if (pv && !pr) begin
            total++;
            if (mem_cmd_valid !== 1'b1 || mem_cmd_write !== pw ||
                mem_cmd_address !== pa || (pw && mem_wr_data !== pd)) begin
               $display("FAIL cmd_stable: got v=%b w=%b a=%h want v=1 w=%b a=%h",
                        mem_cmd_valid, mem_cmd_write, mem_cmd_address, pw, pa);
            end else passed++;
         end
         if (mem_cmd_valid && mem_cmd_ready) begin
            total++;
            if (cmd_q.size() == 0) begin
               $display("FAIL cmd_unexpected: got w=%b a=%h want no command",
                        mem_cmd_write, mem_cmd_address);
            end else begin
               cmd_t e;
               e = cmd_q.pop_front();
               if (mem_cmd_write !== e.w || mem_cmd_address !== e.a ||
                   (e.w && mem_wr_data !== e.d)) begin
                  $display("FAIL cmd: got w=%b a=%h d=%h want w=%b a=%h d=%h",
                           mem_cmd_write, mem_cmd_address, mem_wr_data,
                           e.w, e.a, e.d);
               end else passed++;
            end
         end
         if (new_data_save) begin
            total++;
            if (fill_q.size() == 0) begin
               $display("FAIL fill_unexpected: got a=%h want no fill",
                        new_address);
            end else begin
               fill_t f;
               f = fill_q.pop_front();
               if (new_address !== f.a || new_data !== f.d) begin
                  $display("FAIL fill: got a=%h d=%h want a=%h d=%h",
                           new_address, new_data, f.a, f.d);
               end else passed++;
            end
         end
         pv = mem_cmd_valid;
         pr = mem_cmd_ready;
         pw = mem_cmd_write;
         pa = mem_cmd_address;
         pd = mem_wr_data;
      end
   end

   task automatic do_miss(
      input logic [AW-1:0] addr,
      input logic          dirty,
      input logic [AW-1:0] saddr,
      input logic [CW-1:0] sdata,
      input logic [CW-1:0] rdata,
      input int            stall,
      input bit            hold_valid,
      input int            exp_lat
   );
      int cyc;
      int wcnt;
      bit done;
      bit rd_pend;
      if (dirty) cmd_q.push_back('{1'b1, saddr & MASK, sdata});
      cmd_q.push_back('{1'b0, addr & MASK, '0});
      fill_q.push_back('{addr & MASK, rdata});
      @(posedge clk); #1;
      miss_valid     = 1'b1;
      miss_address   = addr;
      save_need_flag = dirty;
      save_address   = saddr;
      save_data      = sdata;
      @(negedge clk);
      total++;
      if (miss_ready !== 1'b1)
         $display("FAIL accept: got miss_ready=%b want 1", miss_ready);
      else passed++;
      @(posedge clk); #1;
      if (!hold_valid) miss_valid = 1'b0;
      miss_address   = ~addr;
      save_need_flag = ~dirty;
      save_address   = ~saddr;
      save_data      = ~sdata;
      cyc = 1; wcnt = 0; done = 0; rd_pend = 0;
      while (!done && cyc < 40) begin
         mem_rd_valid = rd_pend;
         mem_rd_data  = rd_pend ? rdata : rnd128();
         rd_pend = 0;
         if (mem_cmd_valid) begin
            if (wcnt < stall) begin
               mem_cmd_ready = 1'b0;
               wcnt++;
            end else begin
               mem_cmd_ready = 1'b1;
               wcnt = 0;
               if (!mem_cmd_write) rd_pend = 1;
            end
         end else mem_cmd_ready = 1'b0;
         @(negedge clk);
         if (hold_valid) begin
            total++;
            if (miss_ready !== 1'b0)
               $display("FAIL busy_ready: got %b want 0 cycle %0d",
                        miss_ready, cyc);
            else passed++;
         end
         if (miss_done) begin
            done = 1;
            total++;
            if (cyc != exp_lat)
               $display("FAIL latency: got %0d want %0d", cyc, exp_lat);
            else passed++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (!done) begin
         total++;
         $display("FAIL timeout: got no miss_done want done in %0d", exp_lat);
      end
      miss_valid    = 1'b0;
      mem_cmd_ready = 1'b0;
      mem_rd_valid  = 1'b0;
      total++;
      if (cmd_q.size() != 0 || fill_q.size() != 0) begin
         $display("FAIL pending: got cmd=%0d fill=%0d want 0 0",
                  cmd_q.size(), fill_q.size());
         cmd_q.delete();
         fill_q.delete();
      end else passed++;
      total++;
      if (new_address !== (addr & MASK) || new_data !== rdata)
         $display("FAIL hold: got a=%h d=%h want a=%h d=%h",
                  new_address, new_data, addr & MASK, rdata);
      else passed++;
   endtask

   task automatic check_idle_zero(input string tag);
      total++;
      if (mem_cmd_valid !== 1'b0 || mem_cmd_write !== 1'b0 ||
          mem_cmd_address !== '0 || mem_wr_data !== '0 ||
          miss_done !== 1'b0 || new_data_save !== 1'b0 ||
          new_address !== '0 || new_data !== '0)
         $display("FAIL %s: got v=%b w=%b a=%h done=%b save=%b na=%h nd=%h want all 0",
                  tag, mem_cmd_valid, mem_cmd_write, mem_cmd_address,
                  miss_done, new_data_save, new_address, new_data);
      else passed++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      miss_valid = 1'b0; miss_address = '0;
      save_need_flag = 1'b0; save_address = '0; save_data = '0;
      mem_cmd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("reset_outputs");
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (miss_ready !== 1'b1)
         $display("FAIL reset_ready: got %b want 1", miss_ready);
      else passed++;
      check_idle_zero("reset_release");
   endtask

   task automatic test_clean_miss();
      do_miss(28'h0A5000F, 1'b0, '0, '0,
              {32'hDEADBEEF, 32'hCAFEBABE, 32'h12345678, 32'h87654321},
              0, 0, 4);
   endtask

   task automatic test_dirty_miss();
      do_miss(28'h0A50084, 1'b1, 28'h0A50060, {4{32'h12345678}},
              rnd128(), 0, 0, 5);
   endtask

   task automatic test_stall();
      do_miss(28'h0123458, 1'b0, '0, '0, rnd128(), 3, 0, 7);
      do_miss(28'h0FFFFFF, 1'b1, 28'h0123457, rnd128(),
              rnd128(), 1, 0, 7);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         logic [AW-1:0] a;
         logic d;
         a = AW'($urandom);
         d = i[0];
         do_miss(a, d, AW'($urandom), rnd128(), rnd128(), 0, 0,
                 d ? 5 : 4);
      end
   endtask

   task automatic test_busy_spurious();
      logic [CW-1:0] held;
      logic [AW-1:0] hadr;
      do_miss(28'h0BEEF07, 1'b1, 28'h0C0FFEE, rnd128(),
              rnd128(), 0, 1, 5);
      held = new_data;
      hadr = new_address;
      for (int i = 0; i < 3; i++) begin
         mem_rd_valid = 1'b1;
         mem_rd_data  = rnd128();
         @(negedge clk);
         total++;
         if (miss_ready !== 1'b1 || mem_cmd_valid !== 1'b0 ||
             new_data_save !== 1'b0 || new_data !== held ||
             new_address !== hadr)
            $display("FAIL spurious_rd: got rdy=%b v=%b save=%b nd=%h want 1 0 0 %h",
                     miss_ready, mem_cmd_valid, new_data_save, new_data, held);
         else passed++;
         @(posedge clk); #1;
      end
      mem_rd_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      int  cyc;
      bit  seen;
      cmd_q.push_back('{1'b0, 28'h0777770, '0});
      @(posedge clk); #1;
      miss_valid = 1'b1;
      miss_address = 28'h0777777;
      save_need_flag = 1'b0;
      @(posedge clk); #1;
      miss_valid = 1'b0;
      cyc = 0; seen = 0;
      while (!seen && cyc < 20) begin
         mem_cmd_ready = mem_cmd_valid;
         seen = mem_cmd_valid;
         @(posedge clk); #1;
         cyc++;
      end
      mem_cmd_ready = 1'b0;
      total++;
      if (!seen) $display("FAIL midrst_cmd: got no read cmd want one");
      else passed++;
      #2;
      rst_n = 1'b0;
      cmd_q.delete();
      fill_q.delete();
      #1;
      check_idle_zero("midrst_outputs");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (miss_ready !== 1'b1)
         $display("FAIL midrst_ready: got %b want 1", miss_ready);
      else passed++;
      @(posedge clk); #1;
      mem_rd_valid = 1'b1;
      mem_rd_data  = rnd128();
      repeat (3) @(posedge clk);
      #1;
      mem_rd_valid = 1'b0;
      @(negedge clk);
      check_idle_zero("midrst_late_rd");
      total++;
      if (miss_ready !== 1'b1)
         $display("FAIL midrst_idle: got %b want 1", miss_ready);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_clean_miss();
      test_dirty_miss();
      test_stall();
      test_back_to_back();
      test_busy_spurious();
      test_reset_mid();
      test_clean_miss();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
